arbitro_prioridade_n: RTL and testbench
=======================================

Name: arbitro_prioridade_n

Overview:
- Clocked, parametrised successor of the two-station combinational priority controller.
- Accepts service requests from NUM_IE input stations. Each request carries a priority level and a function code.
- Latches pending requests, grants exactly one station at a time for a fixed service window, and breaks ties round-robin.
- Optionally preempts the current grant when a strictly higher-priority request is pending. Outputs drive the LED/RGB status layer of the top level.

Parameters:
- NUM_IE, 2, number of requesting stations (2..8).
- PRIO_W, 2, width of the priority field per station; larger value = higher priority.
- FUN_W, 3, width of the function code per station.
- SERVICE_CYCLES, 4, clock cycles a grant is held (>=1).
- PREEMPT, 0, 1 = strictly higher priority aborts the current grant.
- IDX_W, derived ceil(log2(NUM_IE)) (minimum 1), width of the station index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NUM_IE  per-station request strobe, sampled every edge.
- cancel_i  in  NUM_IE  per-station withdraw strobe.
- prio_i  in  NUM_IE*PRIO_W  priorities; station k occupies bits [k*PRIO_W +: PRIO_W].
- fun_i  in  NUM_IE*FUN_W  function codes; same packing as prio_i.
- grant_o  out  NUM_IE  one-hot grant, all zero when idle.
- grant_valid_o  out  1  OR of grant_o.
- station_o  out  IDX_W  index of the granted station.
- fun_o  out  FUN_W  latched function code of the granted station.
- busy_o  out  1  high when any request is pending or granted.
- tie_o  out  1  the last arbitration had 2 or more candidates at the max priority.
- preempt_o  out  1  one-cycle pulse when a grant was preempted.
- done_o  out  1  one-cycle pulse when a service window completes normally.

Behaviour:
- Reset (asynchronous):
  - all outputs 0; pending[] = 0; latched prio/fun = 0.
  - rr_ptr = 0; counter = 0; state = IDLE.
- Pending latch, per station k, on each edge:
  - cancel_i[k] has precedence over req_i[k]: clears pending[k].
  - else if req_i[k] and k is not the current grantee: pending[k] = 1 and prio/fun are latched. If k is already pending, the latched values are overwritten.
  - req_i[k] from the current grantee is ignored.
- Selection: among pending stations, highest latched priority wins. Ties are resolved by scanning from rr_ptr upward with wrap (index NUM_IE-1 -> 0).
- FSM states: IDLE, SERVE.
- IDLE:
  - if any pending: register the winner into grant_o, station_o and fun_o.
  - load counter = SERVICE_CYCLES-1; set tie_o; go to SERVE.
- Latency: req_i high at edge t -> pending at t -> grant_o visible after edge t+1.
- SERVE, counter > 0: decrement counter.
- SERVE, counter == 0:
  - done_o = 1 for one cycle; clear pending of the grantee.
  - rr_ptr = (grantee+1) mod NUM_IE; grant_o = 0; go to IDLE.
  - Re-arbitration happens at the following edge, so there is 1 idle cycle between consecutive grants.
- Preemption (PREEMPT=1 only): in SERVE, if some pending non-grantee has priority strictly greater than the grantee's:
  - next edge: preempt_o = 1; grant moves to the new winner (selection rule applies, grantee excluded); counter reloads; tie_o is updated.
  - the old grantee stays pending with its latched values; rr_ptr is unchanged.
  - Equal priority never preempts. Preemption takes precedence over done on the same edge.
- Cancel of the grantee in SERVE: grant_o = 0 at the next edge; no done_o; pending cleared; go to IDLE; rr_ptr = grantee+1.
- tie_o holds its value until the next arbitration. busy_o is combinational from pending and state.
- rst asserted mid-service: immediate return to the reset state; no done_o or preempt_o is emitted.

Test Plan:
- Single request. NUM_IE=2: req_i=01, prio 2, fun 5 at edge 0.
  -> grant_o=01, fun_o=5 from edge 1 through edge 4.
  -> done_o pulse after edge 4.
  -> grant_o=00 and busy_o=0 after edge 5.
- Priority. Both request in the same cycle, prio0=1, prio1=3.
  -> station 1 granted first, tie_o=0.
  -> station 0 granted 1 idle cycle after done_o.
- Round-robin. Both stations at prio 2, requests re-issued continually, 3 windows.
  -> grant order 0, 1, 0, with tie_o=1 each time.
- Preemption. PREEMPT=1; station 0 granted at prio 1; station 1 requests prio 3 at the 2nd service cycle.
  -> preempt_o pulse; grant_o=10.
  -> station 0 re-granted after station 1's done_o.
- Same stimulus with PREEMPT=0.
  -> no preempt_o; station 0 completes its 4 cycles first.
- Cancel and reset.
  - cancel_i of the grantee mid-window -> grant drops at the next edge, no done_o.
  - rst pulsed mid-window -> all outputs 0 immediately; pending cleared.

Source files
------------

// File: rtl/arbitro_prioridade_n.sv
// Clocked N-station priority arbiter: latches requests, grants one station per
// fixed service window, round-robin tie break, optional preemption by strictly higher priority.
module arbitro_prioridade_n #(
  parameter int NUM_IE         = 2,
  parameter int PRIO_W         = 2,
  parameter int FUN_W          = 3,
  parameter int SERVICE_CYCLES = 4,
  parameter int PREEMPT        = 0,
  localparam int IDX_W         = (NUM_IE > 1) ? $clog2(NUM_IE) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IE-1:0]          req_i,
  input  logic [NUM_IE-1:0]          cancel_i,
  input  logic [NUM_IE*PRIO_W-1:0]   prio_i,
  input  logic [NUM_IE*FUN_W-1:0]    fun_i,
  output logic [NUM_IE-1:0]          grant_o,
  output logic                       grant_valid_o,
  output logic [IDX_W-1:0]           station_o,
  output logic [FUN_W-1:0]           fun_o,
  output logic                       busy_o,
  output logic                       tie_o,
  output logic                       preempt_o,
  output logic                       done_o
);

  localparam int CNT_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t               state, state_nxt;
  logic [NUM_IE-1:0]    pending;
  logic [PRIO_W-1:0]    lat_prio [NUM_IE];
  logic [FUN_W-1:0]     lat_fun  [NUM_IE];
  logic [IDX_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     counter;

  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [PRIO_W-1:0]    win_prio;
  logic                 win_tie;
  logic                 preempt_now;
  logic                 cancel_gnt;
  logic                 done_now;
  logic                 arbitrate;
  logic                 release_gnt;
  logic [IDX_W-1:0]     rr_next;

  // Winner search: scan from rr_ptr with wrap; only a strictly higher priority
  // displaces an earlier candidate, so the first in scan order wins ties.
  always_comb begin
    int k;
    int n_max;
    k        = 0;
    n_max    = 0;
    win_vld  = 1'b0;
    win_idx  = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_IE; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_IE) k = k - NUM_IE;
      if (pending[k] && !grant_o[k] && (!win_vld || lat_prio[k] > win_prio)) begin
        win_vld  = 1'b1;
        win_idx  = IDX_W'(k);
        win_prio = lat_prio[k];
      end
    end
    for (int i = 0; i < NUM_IE; i++) begin
      if (pending[i] && !grant_o[i] && lat_prio[i] == win_prio) n_max = n_max + 1;
    end
    win_tie = win_vld && (n_max >= 2);
  end

  assign preempt_now = (PREEMPT != 0) && (state == SERVE) && win_vld &&
                       (win_prio > lat_prio[station_o]);
  assign cancel_gnt  = (state == SERVE) && |(cancel_i & grant_o);
  assign done_now    = (state == SERVE) && (counter == '0) && !preempt_now && !cancel_gnt;
  assign arbitrate   = ((state == IDLE) && win_vld) || preempt_now;
  assign release_gnt = !preempt_now && (cancel_gnt || done_now);
  assign rr_next     = (station_o == IDX_W'(NUM_IE - 1)) ? '0 : station_o + 1'b1;

  assign done_o        = done_now;
  assign grant_valid_o = |grant_o;
  assign busy_o        = (|pending) || (state == SERVE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = SERVE;
      SERVE:   if (release_gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request latch: a grantee's own request is only accepted on the edge its window ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int k = 0; k < NUM_IE; k++) begin
        lat_prio[k] <= '0;
        lat_fun[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_IE; k++) begin
        if (cancel_i[k]) begin
          pending[k] <= 1'b0;
        end else if (req_i[k] && !(grant_o[k] && !done_now)) begin
          pending[k]  <= 1'b1;
          lat_prio[k] <= prio_i[k*PRIO_W +: PRIO_W];
          lat_fun[k]  <= fun_i[k*FUN_W +: FUN_W];
        end else if (grant_o[k] && done_now) begin
          pending[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_o   <= '0;
      station_o <= '0;
      fun_o     <= '0;
      tie_o     <= 1'b0;
      preempt_o <= 1'b0;
      rr_ptr    <= '0;
      counter   <= '0;
    end else begin
      preempt_o <= preempt_now;
      if (arbitrate) begin
        grant_o   <= NUM_IE'(1) << win_idx;
        station_o <= win_idx;
        fun_o     <= lat_fun[win_idx];
        tie_o     <= win_tie;
        counter   <= CNT_W'(SERVICE_CYCLES - 1);
      end else if (state == SERVE) begin
        if (release_gnt) begin
          grant_o <= '0;
          rr_ptr  <= rr_next;
        end else begin
          counter <= counter - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arbitro_prioridade_n.sv
// Directed bench: two arbiters (PREEMPT=0 and PREEMPT=1) share one stimulus stream.
module tb_arbitro_prioridade_n;

  logic       clk;
  logic       rst;
  logic [1:0] req_i;
  logic [1:0] cancel_i;
  logic [3:0] prio_i;
  logic [5:0] fun_i;

  logic [1:0] grant_o,  grant_p;
  logic       gv_o,     gv_p;
  logic       stn_o,    stn_p;
  logic [2:0] fun_o,    fun_p;
  logic       busy_o,   busy_p;
  logic       tie_o,    tie_p;
  logic       pre_o,    pre_p;
  logic       done_o,   done_p;

  int total;
  int bad;

  arbitro_prioridade_n #(.NUM_IE(2), .PRIO_W(2), .FUN_W(3), .SERVICE_CYCLES(4), .PREEMPT(0)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .cancel_i(cancel_i), .prio_i(prio_i), .fun_i(fun_i),
    .grant_o(grant_o), .grant_valid_o(gv_o), .station_o(stn_o), .fun_o(fun_o),
    .busy_o(busy_o), .tie_o(tie_o), .preempt_o(pre_o), .done_o(done_o));

  arbitro_prioridade_n #(.NUM_IE(2), .PRIO_W(2), .FUN_W(3), .SERVICE_CYCLES(4), .PREEMPT(1)) dut_p (
    .clk(clk), .rst(rst), .req_i(req_i), .cancel_i(cancel_i), .prio_i(prio_i), .fun_i(fun_i),
    .grant_o(grant_p), .grant_valid_o(gv_p), .station_o(stn_p), .fun_o(fun_p),
    .busy_o(busy_p), .tie_o(tie_p), .preempt_o(pre_p), .done_o(done_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_i = '0; cancel_i = '0; prio_i = '0; fun_i = '0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = '0; cancel_i = '0; prio_i = '0; fun_i = '0;
    #2;
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
    total++; if ({gv_o, busy_o, tie_o, pre_o, done_o} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {gv_o, busy_o, tie_o, pre_o, done_o}); end
    total++; if ({stn_o, fun_o} !== 4'h0) begin bad++; $display("FAIL reset_stn_fun got=%h exp=0", {stn_o, fun_o}); end
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_single();
    do_reset();
    req_i = 2'b01; prio_i = {2'd0, 2'd2}; fun_i = {3'd0, 3'd5};
    step(1);
    req_i = 2'b00;
    total++; if (grant_o !== 2'b00 || busy_o !== 1'b1) begin bad++; $display("FAIL single_pending got=%b/%b exp=00/1", grant_o, busy_o); end
    step(1);
    total++; if (grant_o !== 2'b01 || fun_o !== 3'd5 || gv_o !== 1'b1) begin bad++; $display("FAIL single_grant got=%b fun=%0d exp=01 fun=5", grant_o, fun_o); end
    step(2);
    total++; if (grant_o !== 2'b01 || done_o !== 1'b0) begin bad++; $display("FAIL single_hold got=%b done=%b exp=01 done=0", grant_o, done_o); end
    step(1);
    total++; if (grant_o !== 2'b01 || done_o !== 1'b1) begin bad++; $display("FAIL single_done got=%b done=%b exp=01 done=1", grant_o, done_o); end
    step(1);
    total++; if (grant_o !== 2'b00 || busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL single_end got=%b busy=%b done=%b exp=00 0 0", grant_o, busy_o, done_o); end
  endtask

  task automatic test_priority();
    do_reset();
    req_i = 2'b11; prio_i = {2'd3, 2'd1}; fun_i = {3'd6, 3'd2};
    step(1);
    req_i = 2'b00;
    step(1);
    total++; if (grant_o !== 2'b10 || stn_o !== 1'b1 || fun_o !== 3'd6 || tie_o !== 1'b0) begin bad++; $display("FAIL prio_first got=%b stn=%b fun=%0d tie=%b exp=10 1 6 0", grant_o, stn_o, fun_o, tie_o); end
    step(3);
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL prio_done got=%b exp=1", done_o); end
    step(1);
    total++; if (grant_o !== 2'b00 || busy_o !== 1'b1) begin bad++; $display("FAIL prio_gap got=%b busy=%b exp=00 1", grant_o, busy_o); end
    step(1);
    total++; if (grant_o !== 2'b01 || fun_o !== 3'd2 || tie_o !== 1'b0) begin bad++; $display("FAIL prio_second got=%b fun=%0d tie=%b exp=01 2 0", grant_o, fun_o, tie_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_i = 2'b11; prio_i = {2'd2, 2'd2}; fun_i = {3'd4, 3'd1};
    step(2);
    total++; if (grant_o !== 2'b01 || tie_o !== 1'b1) begin bad++; $display("FAIL rr_win1 got=%b tie=%b exp=01 1", grant_o, tie_o); end
    step(4);
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rr_gap got=%b exp=00", grant_o); end
    step(1);
    total++; if (grant_o !== 2'b10 || tie_o !== 1'b1 || fun_o !== 3'd4) begin bad++; $display("FAIL rr_win2 got=%b tie=%b fun=%0d exp=10 1 4", grant_o, tie_o, fun_o); end
    total++; if (grant_p !== 2'b10 || pre_p !== 1'b0) begin bad++; $display("FAIL rr_equal_no_preempt got=%b pre=%b exp=10 0", grant_p, pre_p); end
    step(5);
    total++; if (grant_o !== 2'b01 || tie_o !== 1'b1) begin bad++; $display("FAIL rr_win3 got=%b tie=%b exp=01 1", grant_o, tie_o); end
    req_i = 2'b00;
  endtask

  task automatic test_preempt();
    do_reset();
    req_i = 2'b01; prio_i = {2'd0, 2'd1}; fun_i = {3'd7, 3'd3};
    step(2);
    req_i = 2'b10; prio_i = {2'd3, 2'd1};
    step(1);
    req_i = 2'b00;
    total++; if (pre_o !== 1'b0 || pre_p !== 1'b0) begin bad++; $display("FAIL pre_early got=%b/%b exp=0/0", pre_o, pre_p); end
    step(1);
    total++; if (pre_p !== 1'b1 || grant_p !== 2'b10 || fun_p !== 3'd7) begin bad++; $display("FAIL pre_switch got pre=%b grant=%b fun=%0d exp=1 10 7", pre_p, grant_p, fun_p); end
    total++; if (pre_o !== 1'b0 || grant_o !== 2'b01) begin bad++; $display("FAIL nopre_hold got pre=%b grant=%b exp=0 01", pre_o, grant_o); end
    step(1);
    total++; if (pre_p !== 1'b0 || done_o !== 1'b1 || done_p !== 1'b0) begin bad++; $display("FAIL pre_pulse got pre=%b done=%b done_p=%b exp=0 1 0", pre_p, done_o, done_p); end
    step(2);
    total++; if (done_p !== 1'b1 || grant_o !== 2'b10) begin bad++; $display("FAIL pre_done got done_p=%b grant=%b exp=1 10", done_p, grant_o); end
    step(2);
    total++; if (grant_p !== 2'b01 || fun_p !== 3'd3 || pre_p !== 1'b0) begin bad++; $display("FAIL pre_regrant got=%b fun=%0d pre=%b exp=01 3 0", grant_p, fun_p, pre_p); end
  endtask

  task automatic test_cancel();
    do_reset();
    req_i = 2'b01; prio_i = {2'd1, 2'd1}; fun_i = {3'd2, 3'd1};
    step(1);
    req_i = 2'b00;
    step(2);
    cancel_i = 2'b01;
    total++; if (done_o !== 1'b0 || grant_o !== 2'b01) begin bad++; $display("FAIL cancel_pre got grant=%b done=%b exp=01 0", grant_o, done_o); end
    step(1);
    cancel_i = 2'b00;
    total++; if (grant_o !== 2'b00 || done_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL cancel_drop got=%b done=%b busy=%b exp=00 0 0", grant_o, done_o, busy_o); end
    req_i = 2'b11;
    step(1);
    req_i = 2'b00;
    step(1);
    total++; if (grant_o !== 2'b10 || tie_o !== 1'b1) begin bad++; $display("FAIL cancel_rr got=%b tie=%b exp=10 1", grant_o, tie_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_i = 2'b01; prio_i = {2'd0, 2'd2}; fun_i = {3'd0, 3'd6};
    step(1);
    step(2);
    #2;
    rst = 1'b1;
    #1;
    total++; if (grant_o !== 2'b00 || {gv_o, busy_o, done_o, pre_o, tie_o} !== 5'b0 || fun_o !== 3'd0) begin bad++; $display("FAIL midrst_out got=%b flags=%b fun=%0d exp=00 00000 0", grant_o, {gv_o, busy_o, done_o, pre_o, tie_o}, fun_o); end
    req_i = 2'b00;
    step(1);
    rst = 1'b0;
    step(2);
    total++; if (grant_o !== 2'b00 || busy_o !== 1'b0) begin bad++; $display("FAIL midrst_pending got=%b busy=%b exp=00 0", grant_o, busy_o); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_preempt();
    test_cancel();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
